// File: rtl/digit_entry_editor.sv
// Digit entry editor: three debounced-by-edge keys edit NUM_DIGITS digits with a blinking cursor.
// Latency: SYNC_STAGES+1 edges from first low key sample to updated outputs; no backpressure.
module digit_entry_editor #(
  parameter int NUM_DIGITS  = 6,
  parameter int RADIX       = 10,
  parameter int SYNC_STAGES = 2,
  parameter int BLINK_DIV   = 25_000_000,
  localparam int PW = ($clog2(NUM_DIGITS) < 1) ? 1 : $clog2(NUM_DIGITS)
) (
  input  logic                    CLOCK_50,
  input  logic                    resetn,
  input  logic                    key_inc,
  input  logic                    key_dec,
  input  logic                    key_adv,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [PW-1:0]           pos,
  output logic [3:0]              cur_val,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic                    done
);

  // Key index: 0 = inc, 1 = dec, 2 = adv
  logic [2:0]                  w_key;
  logic [2:0][SYNC_STAGES-1:0] r_sync;
  logic [2:0]                  r_hist;
  logic [2:0]                  w_lvl;
  logic [2:0]                  w_evt;

  logic [3:0]    r_digit [NUM_DIGITS];
  logic [PW-1:0] r_pos;
  logic          r_done;
  logic          w_phase;

  logic [3:0] w_cur;
  logic [3:0] w_inc_val;
  logic [3:0] w_dec_val;
  logic       w_do_inc;
  logic       w_do_dec;
  logic       w_last;

  assign w_key = {key_adv, key_dec, key_inc};

  // Flops reset to the pressed level so a key held through reset release cannot fire.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_sync <= '0;
      r_hist <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        r_sync[k] <= {r_sync[k][SYNC_STAGES-2:0], w_key[k]};
        r_hist[k] <= r_sync[k][SYNC_STAGES-1];
      end
    end
  end

  always_comb begin
    w_lvl = '0;
    for (int k = 0; k < 3; k++) begin
      w_lvl[k] = r_sync[k][SYNC_STAGES-1];
    end
  end

  assign w_evt = ~w_lvl & r_hist;

  always_comb begin
    w_cur = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_pos == PW'(i)) begin
        w_cur = r_digit[i];
      end
    end
  end

  // Simultaneous inc and dec cancel out.
  assign w_do_inc  = w_evt[0] & ~w_evt[1];
  assign w_do_dec  = w_evt[1] & ~w_evt[0];
  assign w_inc_val = (w_cur == 4'(RADIX-1)) ? 4'd0 : w_cur + 4'd1;
  assign w_dec_val = (w_cur == 4'd0) ? 4'(RADIX-1) : w_cur - 4'd1;
  assign w_last    = (r_pos == PW'(NUM_DIGITS-1));

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_digit[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (r_pos == PW'(i)) begin
          if (w_do_inc) begin
            r_digit[i] <= w_inc_val;
          end else if (w_do_dec) begin
            r_digit[i] <= w_dec_val;
          end
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_pos  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_evt[2] & w_last;
      if (w_evt[2]) begin
        r_pos <= w_last ? '0 : r_pos + PW'(1);
      end
    end
  end

  generate
    if (BLINK_DIV > 0) begin : g_blink
      localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
      logic [BW-1:0] r_cnt;
      logic          r_ph;

      // Any press restarts the blink so the cursor is visible right after editing.
      always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
          r_cnt <= '0;
          r_ph  <= 1'b0;
        end else if (|w_evt) begin
          r_cnt <= '0;
          r_ph  <= 1'b0;
        end else if (r_cnt == BW'(BLINK_DIV-1)) begin
          r_cnt <= '0;
          r_ph  <= ~r_ph;
        end else begin
          r_cnt <= r_cnt + BW'(1);
        end
      end

      assign w_phase = r_ph;
    end else begin : g_noblink
      assign w_phase = 1'b0;
    end
  endgenerate

  function automatic logic [6:0] f_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    hex    = '1;
    digits = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digits[4*i +: 4] = r_digit[i];
      if ((r_pos == PW'(i)) && w_phase) begin
        hex[7*i +: 7] = 7'b1111111;
      end else begin
        hex[7*i +: 7] = f_seg(r_digit[i]);
      end
    end
  end

  assign pos     = r_pos;
  assign cur_val = w_cur;
  assign done    = r_done;

endmodule

// File: tb/tb_digit_entry_editor.sv
// Bench for digit_entry_editor: directed and random key presses, expected outputs queued per cycle
// from a digit/cursor/blink model and compared by an independent negedge monitor.
module tb_digit_entry_editor;

  localparam int ND    = 6;
  localparam int RADIX = 10;
  localparam int SYNC  = 2;
  localparam int BL    = 4;
  localparam int PW    = 3;

  logic              clk;
  logic              resetn;
  logic              key_inc;
  logic              key_dec;
  logic              key_adv;
  logic [4*ND-1:0]   digits;
  logic [PW-1:0]     pos;
  logic [3:0]        cur_val;
  logic [7*ND-1:0]   hex;
  logic              done;

  digit_entry_editor #(
    .NUM_DIGITS (ND),
    .RADIX      (RADIX),
    .SYNC_STAGES(SYNC),
    .BLINK_DIV  (BL)
  ) dut (
    .CLOCK_50(clk),
    .resetn  (resetn),
    .key_inc (key_inc),
    .key_dec (key_dec),
    .key_adv (key_adv),
    .digits  (digits),
    .pos     (pos),
    .cur_val (cur_val),
    .hex     (hex),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [4*ND-1:0] dig;
    int          pos;
    bit          done;
    bit          ph;
  } item_t;

  item_t q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference state: digit values, cursor, and the cycle at which the blink last restarted.
  int md[ND];
  int mpos;
  int mclr;

  function automatic logic [6:0] tb_seg(input int v);
    case (v)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      10: return 7'b0001000;
      11: return 7'b0000011;
      12: return 7'b1000110;
      13: return 7'b0100001;
      14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic bit f_phase(input int c, input int c0);
    if (BL == 0) return 1'b0;
    return (((c - c0) / BL) % 2) == 1;
  endfunction

  function automatic logic [4*ND-1:0] pack_dig();
    logic [4*ND-1:0] d;
    d = '0;
    for (int i = 0; i < ND; i++) d[4*i +: 4] = 4'(md[i]);
    return d;
  endfunction

  task automatic push_items(input int c_from, input int c_to, input logic [4*ND-1:0] d,
                            input int p, input int c0, input int done_c);
    item_t it;
    for (int c = c_from; c <= c_to; c++) begin
      it.cyc  = c;
      it.dig  = d;
      it.pos  = p;
      it.done = (c == done_c);
      it.ph   = f_phase(c, c0);
      q.push_back(it);
    end
  endtask

  task automatic push_reset_items(input int c_from, input int c_to);
    item_t it;
    for (int c = c_from; c <= c_to; c++) begin
      it.cyc  = c;
      it.dig  = '0;
      it.pos  = 0;
      it.done = 1'b0;
      it.ph   = 1'b0;
      q.push_back(it);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // m[0]=inc, m[1]=dec, m[2]=adv; keys low for L cycles, then high for H+G cycles.
  task automatic do_op(input logic [2:0] m, input int L, input int H, input int G);
    int n, due, t, opos, oclr, done_c;
    logic [4*ND-1:0] od;
    n      = cyc;
    t      = L + H + G;
    due    = n + SYNC + 1;
    od     = pack_dig();
    opos   = mpos;
    oclr   = mclr;
    done_c = -1;
    if (m != 3'b000) begin
      if (m[0] && !m[1]) md[mpos] = (md[mpos] + 1) % RADIX;
      if (m[1] && !m[0]) md[mpos] = (md[mpos] + RADIX - 1) % RADIX;
      if (m[2]) begin
        if (mpos == ND - 1) done_c = due;
        mpos = (mpos + 1) % ND;
      end
      mclr = due;
      push_items(n + 1, due - 1, od, opos, oclr, -1);
      push_items(due, n + t, pack_dig(), mpos, mclr, done_c);
    end else begin
      push_items(n + 1, n + t, od, opos, oclr, -1);
    end
    key_inc = ~m[0];
    key_dec = ~m[1];
    key_adv = ~m[2];
    repeat (L) step();
    key_inc = 1'b1;
    key_dec = 1'b1;
    key_adv = 1'b1;
    repeat (H + G) step();
  endtask

  // Hold inc, pulse reset mid-hold, release reset with the key still low, then release the key.
  task automatic reset_mid_press();
    int n;
    n = cyc;
    push_items(n + 1, n + 1, pack_dig(), mpos, mclr, -1);
    key_inc = 1'b0;
    step();
    step();
    resetn = 1'b0;
    for (int i = 0; i < ND; i++) md[i] = 0;
    mpos = 0;
    push_reset_items(n + 2, n + 5);
    repeat (4) step();
    resetn = 1'b1;
    mclr   = n + 6;
    push_items(n + 6, n + 15, '0, 0, mclr, -1);
    repeat (4) step();
    key_inc = 1'b1;
    repeat (5) step();
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp, input int c);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, c, act, exp);
    end
  endtask

  item_t           mon_it;
  logic [7*ND-1:0] mon_hex;
  logic [3:0]      mon_cur;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      if (q[0].cyc < cyc) begin
        mon_it = q.pop_front();
        checks++;
        errors++;
        $display("FAIL stale_item cyc=%0d actual=%0d expected=%0d", cyc, cyc, mon_it.cyc);
      end else if (q[0].cyc == cyc) begin
        mon_it  = q.pop_front();
        mon_hex = '1;
        for (int i = 0; i < ND; i++) begin
          if (i == mon_it.pos && mon_it.ph) mon_hex[7*i +: 7] = 7'b1111111;
          else mon_hex[7*i +: 7] = tb_seg(int'(mon_it.dig[4*i +: 4]));
        end
        mon_cur = mon_it.dig[4*mon_it.pos +: 4];
        chk("digits",  64'(digits),  64'(mon_it.dig),  cyc);
        chk("pos",     64'(pos),     64'(mon_it.pos),  cyc);
        chk("cur_val", 64'(cur_val), 64'(mon_cur),     cyc);
        chk("hex",     64'(hex),     64'(mon_hex),     cyc);
        chk("done",    64'(done),    64'(mon_it.done), cyc);
      end
    end
  end

  localparam logic [2:0] K_INC = 3'b001;
  localparam logic [2:0] K_DEC = 3'b010;
  localparam logic [2:0] K_ADV = 3'b100;

  initial begin
    int g;
    resetn  = 1'b0;
    key_inc = 1'b1;
    key_dec = 1'b1;
    key_adv = 1'b1;
    for (int i = 0; i < ND; i++) md[i] = 0;
    mpos = 0;
    mclr = 0;

    step();
    push_reset_items(1, 3);
    repeat (3) step();
    resetn = 1'b1;
    mclr   = cyc;
    push_items(cyc, cyc + 4, '0, 0, mclr, -1);
    repeat (4) step();

    do_op(K_INC, 2, 3, 0);
    do_op(K_INC, 1, 4, 0);
    do_op(K_ADV, 2, 3, 0);
    do_op(K_DEC, 3, 3, 0);
    do_op(K_INC, 1, 3, 0);
    repeat (5) do_op(K_ADV, 2, 3, 1);
    repeat (2) do_op(K_ADV, 1, 3, 0);
    do_op(K_INC | K_DEC, 2, 3, 0);
    do_op(K_INC | K_ADV, 2, 3, 0);
    do_op(3'b000, 1, 3, 20);
    do_op(K_DEC, 1, 3, 12);

    reset_mid_press();
    do_op(K_INC, 2, 3, 6);

    for (int n = 0; n < 300; n++) begin
      g = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 20) : $urandom_range(0, 2);
      do_op(3'($urandom_range(0, 7)), $urandom_range(1, 4), $urandom_range(3, 5), g);
      if (n == 150) reset_mid_press();
    end

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_entry_editor.md
DIGIT_ENTRY_EDITOR -- requirements
Module: digit_entry_editor

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, number of editable digits (legal 2..8).
REQ-002 SHALL have parameter RADIX, default 10, digit base (legal 2..16).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, button synchroniser depth (legal >=2).
REQ-004 SHALL have parameter BLINK_DIV, default 25_000_000, cursor blink half-period in cycles; 0 disables blinking.
REQ-005 SHALL have port CLOCK_50  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have port resetn  in  1  one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port key_inc  in  1  active-low button, increment digit at cursor.
REQ-008 SHALL have port key_dec  in  1  active-low button, decrement digit at cursor.
REQ-009 SHALL have port key_adv  in  1  active-low button, advance cursor.
REQ-010 SHALL have port digits  out  4*NUM_DIGITS  packed digit values, digit i at [4i+3:4i].
REQ-011 SHALL have port pos  out  PW = max(1, clog2(NUM_DIGITS))  cursor position.
REQ-012 SHALL have port cur_val  out  4  value of digit at pos.
REQ-013 SHALL have port hex  out  7*NUM_DIGITS  active-low segments gfedcba, digit i at [7i+6:7i].
REQ-014 SHALL have port done  out  1  one-cycle pulse on cursor wrap.

Function
REQ-015 Each key SHALL pass through a SYNC_STAGES flop chain, followed by one edge-history flop.
REQ-016 A press event SHALL fire when the synchronised level is 0 and the edge-history level is 1. Each press yields exactly one event, regardless of hold time.
REQ-017 Effects of a press SHALL be visible on outputs after the (SYNC_STAGES+1)th rising edge following the first edge that samples the key low.
REQ-018 inc event: digit[pos] <= (digit[pos]==RADIX-1) ? 0 : digit[pos]+1.
REQ-019 dec event: digit[pos] <= (digit[pos]==0) ? RADIX-1 : digit[pos]-1.
REQ-020 inc and dec events in the same cycle SHALL leave the digit unchanged.
REQ-021 adv event: pos <= pos+1; when pos==NUM_DIGITS-1, pos <= 0 and done=1 for exactly that one cycle. Digits are retained.
REQ-022 inc/dec coincident with adv SHALL modify the digit at the old pos, then pos advances in the same edge.
REQ-023 Digits SHALL never hold a value >= RADIX. Upper nibble bits above RADIX range read 0.
REQ-024 cur_val SHALL be combinational from digits and pos with zero latency.
REQ-025 Blink counter SHALL count 0..BLINK_DIV-1 and wrap; at each wrap the blink phase SHALL toggle.
REQ-026 Any press event (inc, dec, or adv) SHALL clear the blink counter and set the phase to 0 on the same edge.
REQ-027 hex digit i SHALL be the 0-F active-low decode of digit[i]. When i==pos and phase==1, it SHALL be 7'b1111111 (blank).
REQ-028 Decode table SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-029 With BLINK_DIV==0, phase SHALL remain 0 and the counter SHALL be absent or held at 0.

Reset
REQ-030 resetn low SHALL immediately and asynchronously clear:
  - all digits to 0
  - pos to 0
  - done to 0
  - blink counter and phase to 0
REQ-031 During reset, hex SHALL read 1000000 on every digit.
REQ-032 Synchroniser and edge-history flops SHALL reset to 0 (pressed level). A key held low across reset release therefore produces no event; only a release followed by a new press counts.
REQ-033 Reset asserted mid-press or mid-blink SHALL discard that activity. No done pulse or digit update SHALL occur on reset release.

Verification
REQ-034 Reset, then 2 key_inc presses -> digit0=2, cur_val=2, hex[6:0]=0100100, pos=0.
REQ-035 key_adv x1, key_dec x1 -> pos=1, digit1=9. key_inc x1 -> digit1=0 (wrap both directions).
REQ-036 NUM_DIGITS=6, six key_adv presses from pos=0 -> pos sequence 1,2,3,4,5,0. done is high for exactly one cycle at the 5->0 step. Digits are unchanged.
REQ-037 key_inc and key_dec falling in the same cycle -> digit unchanged. key_inc coincident with key_adv at pos=2 -> digit2 +1, pos=3.
REQ-038 BLINK_DIV=4, no presses -> cursor hex blanks for 4 cycles, shows for 4 cycles, repeating; a press restores visibility on the same edge.
REQ-039 Hold key_inc low, pulse resetn low mid-hold, release reset with key still low -> digits stay 0 after release. Release then press again -> digit0=1.
